// File: rtl/ttt_status_tx.sv
// ttt_status_tx: serialises the tic-tac-toe board status as a 14-byte ASCII
// frame ("C", cursor digit, nine cell chars, win char, CR, LF) over a UART
// line. A frame starts whenever the sampled inputs change or send pulses.
// Events that arrive while a frame is in flight coalesce into one follow-up
// frame.
//
// Build option: define TTT_TX_PARITY_EN for 8E1 framing (even parity bit
// between data and stop). Without it the format is 8N1.
//
// Handshake: there is no ready/valid pair. send is a fire-and-forget pulse
// and busy is high for exactly the cycles in which the line carries a frame.
// dbg_state exposes the FSM encoding for assertion binding.
module ttt_status_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] current_cell,
  input  logic [8:0] cell_select_flag,
  input  logic       win_flag,
  input  logic       send,
  output logic       tx_out,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // The stop bit is one cycle shorter because NEXT supplies its final
  // high cycle; that keeps bytes back-to-back with full-length stop bits.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    LAST_BYTE = 4'd13;

`ifdef TTT_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_NEXT   = 3'd4,
    S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_NEXT   = 3'd4
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic            pending_q, pending_d;
  logic            load;

  logic [3:0]      prev_cell_q;
  logic [8:0]      prev_flag_q;
  logic            prev_win_q;
  logic [3:0]      snap_cell_q;
  logic [8:0]      snap_flag_q;
  logic            snap_win_q;

  logic            in_change;
  logic            in_event;
  logic            trigger;
  logic            baud_last;
  logic            stop_last;
  logic [7:0]      cur_byte;
  logic            tx_d;

  function automatic logic [7:0] cell_char(input logic f);
    return f ? 8'h58 : 8'h2E;
  endfunction

  // Event detection against last cycle's inputs.
  always_comb begin
    in_change = ({current_cell, cell_select_flag, win_flag} !=
                 {prev_cell_q, prev_flag_q, prev_win_q});
    in_event  = in_change | send;
    trigger   = in_event | pending_q;
    baud_last = (baud_q == BAUD_LAST);
    stop_last = (baud_q == STOP_LAST);
  end

  // Byte currently being sent, built only from the snapshot.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_q)
      4'd0:    cur_byte = 8'h43;
      4'd1:    cur_byte = (snap_cell_q <= 4'd8) ? (8'h30 + {4'h0, snap_cell_q}) : 8'h3F;
      4'd2:    cur_byte = cell_char(snap_flag_q[0]);
      4'd3:    cur_byte = cell_char(snap_flag_q[1]);
      4'd4:    cur_byte = cell_char(snap_flag_q[2]);
      4'd5:    cur_byte = cell_char(snap_flag_q[3]);
      4'd6:    cur_byte = cell_char(snap_flag_q[4]);
      4'd7:    cur_byte = cell_char(snap_flag_q[5]);
      4'd8:    cur_byte = cell_char(snap_flag_q[6]);
      4'd9:    cur_byte = cell_char(snap_flag_q[7]);
      4'd10:   cur_byte = cell_char(snap_flag_q[8]);
      4'd11:   cur_byte = snap_win_q ? 8'h57 : 8'h2D;
      4'd12:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // FSM next-state, counters and pending flag.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pending_d = pending_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        if (trigger) begin
          state_d   = S_START;
          load      = 1'b1;
          pending_d = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef TTT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef TTT_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (stop_last) begin
          state_d = S_NEXT;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_NEXT: begin
        baud_d = '0;
        if (byte_q == LAST_BYTE) begin
          state_d = S_IDLE;
          byte_d  = '0;
        end else begin
          state_d = S_START;
          byte_d  = byte_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Anything seen mid-frame earns exactly one follow-up frame.
    if (state_q != S_IDLE && in_event) begin
      pending_d = 1'b1;
    end
  end

  // Line level for the coming cycle, so tx_out is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_d];
`ifdef TTT_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, input history, snapshot and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      pending_q   <= 1'b0;
      prev_cell_q <= '0;
      prev_flag_q <= '0;
      prev_win_q  <= 1'b0;
      snap_cell_q <= '0;
      snap_flag_q <= '0;
      snap_win_q  <= 1'b0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      pending_q   <= pending_d;
      prev_cell_q <= current_cell;
      prev_flag_q <= cell_select_flag;
      prev_win_q  <= win_flag;
      if (load) begin
        snap_cell_q <= current_cell;
        snap_flag_q <= cell_select_flag;
        snap_win_q  <= win_flag;
      end
      tx_out      <= tx_d;
      busy        <= (state_d != S_IDLE);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ttt_status_tx.sv
// Bench for ttt_status_tx at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
// A frame-level reference model pushes expected bytes into exp_q; a UART
// receiver process decodes tx_out and compares each byte it sees.
module tb_ttt_status_tx;

  localparam int CPB = 10;
`ifdef TTT_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam int FRAME_CYC = 14 * BITS_PER_BYTE * CPB;
  localparam int BYTE_CYC  = BITS_PER_BYTE * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] current_cell = '0;
  logic [8:0] cell_select_flag = '0;
  logic       win_flag = 1'b0;
  logic       send = 1'b0;
  logic       tx_out;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  ttt_status_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_cell     (current_cell),
    .cell_select_flag (cell_select_flag),
    .win_flag         (win_flag),
    .send             (send),
    .tx_out           (tx_out),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  logic [13:0] m_prev = '0;
  bit          m_pend = 1'b0;
  int          m_rem = 0;

  task automatic push_frame(input logic [3:0] c, input logic [8:0] f, input logic w);
    exp_q.push_back(8'h43);
    exp_q.push_back((c <= 4'd8) ? 8'h30 + 8'(c) : 8'h3F);
    for (int i = 0; i < 9; i++) exp_q.push_back(f[i] ? 8'h58 : 8'h2E);
    exp_q.push_back(w ? 8'h57 : 8'h2D);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Each negedge stands for the rising edge that follows it.
  always @(negedge clk) begin
    bit ev;
    if (reset) begin
      m_prev = '0;
      m_pend = 1'b0;
      m_rem  = 0;
      exp_q.delete();
    end else begin
      ev = ({current_cell, cell_select_flag, win_flag} != m_prev) || send;
      if (m_rem == 0) begin
        if (ev || m_pend) begin
          push_frame(current_cell, cell_select_flag, win_flag);
          m_rem  = FRAME_CYC;
          m_pend = 1'b0;
        end
      end else begin
        if (ev) m_pend = 1'b1;
        m_rem--;
      end
      m_prev = {current_cell, cell_select_flag, win_flag};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         low_len = 0;
  bit         low_done = 1'b0;
  logic [7:0] rx_byte = '0;
  int         byte_in_frame = 0;
  int         busy_len = 0;

  always @(negedge clk) begin
    int k;
    logic [7:0] e;
    if (reset) begin
      rx_act        = 1'b0;
      byte_in_frame = 0;
      busy_len      = 0;
    end else begin
      if (busy) busy_len++;
      else if (busy_len != 0) begin
        check("busy_len", busy_len, FRAME_CYC);
        busy_len = 0;
      end
      if (!rx_act) begin
        if (tx_out == 1'b0) begin
          rx_act   = 1'b1;
          rx_cnt   = 0;
          low_len  = 1;
          low_done = 1'b0;
          rx_byte  = '0;
        end
      end else begin
        rx_cnt++;
        if (!low_done) begin
          if (tx_out == 1'b0) low_len++;
          else begin
            low_done = 1'b1;
            if (byte_in_frame == 0) check("start_len", low_len, CPB);
          end
        end
        if (rx_cnt % CPB == CPB / 2) begin
          k = rx_cnt / CPB;
          if (k == 0) check("start_bit", tx_out, 0);
          else if (k <= 8) rx_byte[k-1] = tx_out;
`ifdef TTT_TX_PARITY_EN
          else if (k == 9) check("parity", tx_out, ^rx_byte);
`endif
          else begin
            check("stop_bit", tx_out, 1);
            if (exp_q.size() == 0) begin
              check("unexpected_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("byte%0d", byte_in_frame), rx_byte, e);
            end
            byte_in_frame = (byte_in_frame == 13) ? 0 : byte_in_frame + 1;
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] c, input logic [8:0] f, input logic w, input bit s);
    @(posedge clk);
    #1;
    current_cell     = c;
    cell_select_flag = f;
    win_flag         = w;
    send             = s;
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_quiet(input string name);
    int t = 0;
    while ((m_rem != 0 || m_pend || exp_q.size() != 0) && t < 4 * FRAME_CYC) begin
      @(posedge clk);
      t++;
    end
    check({name, "_drained"}, (t < 4 * FRAME_CYC), 1);
    idle_cycles(20);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    idle_cycles(3);
    @(negedge clk);
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(50);
    check("idle_after_reset_busy", busy, 0);

    // Cursor on centre, empty board.
    drive(4'd4, 9'h000, 1'b0, 1'b0);
    wait_quiet("frame_c4");

    // Two corners taken, cursor at 8, won.
    drive(4'd8, 9'b100000001, 1'b1, 1'b0);
    wait_quiet("frame_c8");

    // Three cursor moves during one frame: one extra frame with the last.
    drive(4'd2, 9'h000, 1'b0, 1'b0);
    idle_cycles(200);
    drive(4'd3, 9'h000, 1'b0, 1'b0);
    idle_cycles(300);
    drive(4'd5, 9'h000, 1'b0, 1'b0);
    idle_cycles(300);
    drive(4'd7, 9'h000, 1'b0, 1'b0);
    wait_quiet("coalesce");

    // Out-of-range cursor with coincident send, then send alone.
    drive(4'd12, 9'h000, 1'b0, 1'b1);
    wait_quiet("cell12_send");
    drive(4'd12, 9'h000, 1'b0, 1'b1);
    wait_quiet("send_only");

    // Reset in the middle of byte 5.
    drive(4'd1, 9'h0F0, 1'b0, 1'b0);
    idle_cycles(5 * BYTE_CYC + 30);
    @(posedge clk);
    #1;
    reset            = 1'b1;
    current_cell     = '0;
    cell_select_flag = '0;
    win_flag         = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_tx", tx_out, 1);
    check("abort_busy", busy, 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);

    // Randomised events, some landing mid-frame.
    for (int i = 0; i < 10; i++) begin
      drive(4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(1, 1600));
    end
    wait_quiet("random");

    idle_cycles(300);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ttt_status_tx.md
TTT_STATUS_TX -- requirements
Module: ttt_status_tx

Interface
REQ-001 Parameter: CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter: BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
REQ-003 Port: clk  input  1  single clock, all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: current_cell  input  4  cursor position, 0..8 valid.
REQ-006 Port: cell_select_flag  input  9  per-cell occupied flags; bit 0 is cell 0.
REQ-007 Port: win_flag  input  1  game-won indication.
REQ-008 Port: send  input  1  single-cycle pulse that forces one status frame.
REQ-009 Port: tx_out  output  1  UART serial line, idle high.
REQ-010 Port: busy  output  1  high while a frame is being shifted out.

Function
REQ-011 The block SHALL register current_cell, cell_select_flag and win_flag every cycle into prev registers; trigger = (inputs != prev) OR send OR pending.
REQ-012 FSM states SHALL be IDLE, START, DATA, (PARITY), STOP, NEXT; IDLE -> START on trigger; START -> DATA -> STOP -> NEXT, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-013 The start bit SHALL appear on tx_out on the edge after the cycle in which trigger is high in IDLE; busy SHALL rise on the same edge.
REQ-014 On leaving IDLE, the block SHALL snapshot the inputs; the frame SHALL use only the snapshot.
REQ-015 Frame SHALL be 14 bytes, 8 data bits LSB-first, 1 stop bit: 'C'(0x43), cell digit, 9 cell chars (cell 0 first), win char, CR(0x0D), LF(0x0A).
REQ-016 Cell digit SHALL be 0x30+current_cell for values 0..8, else '?'(0x3F).
REQ-017 Cell char SHALL be 'X'(0x58) if the flag is set, else '.'(0x2E); win char SHALL be 'W'(0x57) if win_flag is set, else '-'(0x2D).
REQ-018 Bytes SHALL be back-to-back: the next start bit SHALL follow the previous stop bit with no idle cycles; NEXT increments the byte index 0..13.
REQ-019 After the stop bit of byte 13, the FSM SHALL return to IDLE, drive tx_out=1, and deassert busy; IDLE SHALL last at least 1 cycle.
REQ-020 Any input change or send pulse while busy SHALL set pending; a pending set SHALL yield exactly one further frame; multiple events during one frame SHALL coalesce into one.
REQ-021 pending SHALL clear when IDLE exits to START.
REQ-022 A send pulse coincident with an input change SHALL produce one frame.

Reset
REQ-023 Reset SHALL force IDLE, tx_out=1, busy=0, pending=0, byte index=0, bit counter=0, baud counter=0, snapshot=0, and prev=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame on the next edge, with tx_out=1 and no partial resume.
REQ-025 After reset release, inputs differing from zero SHALL trigger one frame by REQ-011.

Configuration
REQ-026 Macro TTT_TX_PARITY_EN: when defined, an even-parity bit over the 8 data bits SHALL be inserted between the data and stop bits (8E1, 11 bits per byte); when undefined, the format SHALL be 8N1 with no PARITY state.

Verification (CLK_FREQ=1000, BAUD=100, CLKS_PER_BIT=10)
REQ-027 Reset, then current_cell=4, flags=0, win=0 -> one frame "C4.........-\r\n"; tx_out low exactly 10 cycles for the start bit; busy high 1400 cycles (8N1).
REQ-028 flags=9'b100000001, cell=8, win=1 -> frame "C8X.......XW\r\n".
REQ-029 cell changes 3 times during a frame -> exactly one additional frame, carrying the last value.
REQ-030 current_cell=12 with a send pulse -> digit byte 0x3F.
REQ-031 Reset asserted at byte 5 -> tx_out=1 on the next edge, busy=0, and no further bits until a new trigger.
REQ-032 With TTT_TX_PARITY_EN defined, byte 'C'(0x43, three ones) -> parity bit 1; frame length 1540 cycles.
